// File: rtl/quantized_line_packer.sv
// Packs the low bitWidth bits of each quantized word LSB-first into L2_WIDTH-bit lines.
// Define QLP_OUTLIER_ESCAPE_EN to escape outliers as an all-ones code followed by the raw word.
module quantized_line_packer #(
    parameter int unsigned L2_WIDTH        = 512,
    parameter int unsigned WordWidth_WIDTH = 32
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       Start,
    input  logic [4:0]                 bitWidth,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [WordWidth_WIDTH-1:0] QuantizedBits,
    input  logic [WordWidth_WIDTH-1:0] OrigFormat,
    input  logic                       IsOutlier,
    input  logic                       Last,
    output logic                       LineValid,
    input  logic                       LineReady,
    output logic [L2_WIDTH-1:0]        LineData,
    output logic                       LineLast,
    output logic [15:0]                OutlierCount,
    output logic                       Busy
);

    localparam int unsigned W      = WordWidth_WIDTH;
    localparam int unsigned ACC_W  = L2_WIDTH + W;
    localparam int unsigned FILL_W = $clog2(L2_WIDTH);
    localparam int unsigned SUM_W  = FILL_W + 1;
    localparam int unsigned LEN_W  = $clog2(W) + 1;

`ifdef QLP_OUTLIER_ESCAPE_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_RAW    = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_FLUSH  = 2'd3
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    bw_q, bw_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                line_valid_q, line_valid_d;
    logic [L2_WIDTH-1:0] line_data_q, line_data_d;
    logic                line_last_q, line_last_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                busy_q, busy_d;

    logic                line_free;
    logic                in_ready_c;
    logic                accept;
    logic [W-1:0]        mask;
    logic                pk_en;
    logic [W-1:0]        pk_chunk;
    logic [LEN_W-1:0]    pk_len;
    logic                pk_last;
    logic [ACC_W-1:0]    merged;
    logic [SUM_W-1:0]    total;

`ifdef QLP_OUTLIER_ESCAPE_EN
    logic [W-1:0]        orig_q, orig_d;
    logic                raw_last_q, raw_last_d;
`else
    logic                unused_orig;
    assign unused_orig = ^OrigFormat;
`endif

    // Backpressure: a word may enter whenever the line register is, or is about to be, free.
    assign line_free  = !line_valid_q || LineReady;
    assign in_ready_c = (state_q == S_ACCEPT) && line_free;
    assign accept     = InValid && in_ready_c;
    assign mask       = (bw_q >= LEN_W'(W)) ? {W{1'b1}} : ((W'(1) << bw_q) - W'(1));

    always_comb begin
        state_d      = state_q;
        bw_d         = bw_q;
        acc_d        = acc_q;
        fill_d       = fill_q;
        line_valid_d = line_valid_q;
        line_data_d  = line_data_q;
        line_last_d  = line_last_q;
        cnt_d        = cnt_q;
`ifdef QLP_OUTLIER_ESCAPE_EN
        orig_d       = orig_q;
        raw_last_d   = raw_last_q;
`endif
        pk_en        = 1'b0;
        pk_chunk     = '0;
        pk_len       = '0;
        pk_last      = 1'b0;

        if (line_valid_q && LineReady) begin
            line_valid_d = 1'b0;
            line_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    bw_d    = (bitWidth == 5'd0) ? LEN_W'(W) : LEN_W'(bitWidth);
                    acc_d   = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (accept) begin
                    if (IsOutlier && (cnt_q != 16'hFFFF)) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    pk_en    = 1'b1;
                    pk_len   = bw_q;
                    pk_chunk = QuantizedBits & mask;
                    pk_last  = Last;
`ifdef QLP_OUTLIER_ESCAPE_EN
                    // Outlier marker now, raw word next cycle; Last is deferred to the raw chunk.
                    if (IsOutlier) begin
                        pk_chunk   = mask;
                        pk_last    = 1'b0;
                        orig_d     = OrigFormat;
                        raw_last_d = Last;
                        state_d    = S_RAW;
                    end
`endif
                    if (pk_last) begin
                        state_d = S_FLUSH;
                    end
                end
            end
`ifdef QLP_OUTLIER_ESCAPE_EN
            S_RAW: begin
                if (line_free) begin
                    pk_en    = 1'b1;
                    pk_len   = LEN_W'(W);
                    pk_chunk = orig_q;
                    pk_last  = raw_last_q;
                    state_d  = raw_last_q ? S_FLUSH : S_ACCEPT;
                end
            end
`endif
            S_FLUSH: begin
                // A nonzero fill here is residue left behind a full non-final line.
                if ((fill_q != '0) && line_free) begin
                    line_valid_d = 1'b1;
                    line_data_d  = acc_q[L2_WIDTH-1:0];
                    line_last_d  = 1'b1;
                    acc_d        = '0;
                    fill_d       = '0;
                end else if ((fill_q == '0) && line_valid_q && LineReady && line_last_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        merged = acc_q | (ACC_W'(pk_chunk) << fill_q);
        total  = SUM_W'(fill_q) + SUM_W'(pk_len);

        if (pk_en) begin
            if (total >= SUM_W'(L2_WIDTH)) begin
                line_valid_d = 1'b1;
                line_data_d  = merged[L2_WIDTH-1:0];
                line_last_d  = pk_last && (total == SUM_W'(L2_WIDTH));
                acc_d        = merged >> L2_WIDTH;
                fill_d       = FILL_W'(total - SUM_W'(L2_WIDTH));
            end else if (pk_last) begin
                // Final chunk leaves a partial line: present it directly, upper bits already zero.
                line_valid_d = 1'b1;
                line_data_d  = merged[L2_WIDTH-1:0];
                line_last_d  = 1'b1;
                acc_d        = '0;
                fill_d       = '0;
            end else begin
                acc_d  = merged;
                fill_d = FILL_W'(total);
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= S_IDLE;
            bw_q         <= '0;
            acc_q        <= '0;
            fill_q       <= '0;
            line_valid_q <= 1'b0;
            line_data_q  <= '0;
            line_last_q  <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bw_q         <= bw_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            line_valid_q <= line_valid_d;
            line_data_q  <= line_data_d;
            line_last_q  <= line_last_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
        end
    end

`ifdef QLP_OUTLIER_ESCAPE_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            orig_q     <= '0;
            raw_last_q <= 1'b0;
        end else begin
            orig_q     <= orig_d;
            raw_last_q <= raw_last_d;
        end
    end
`endif

    assign InReady      = in_ready_c;
    assign LineValid    = line_valid_q;
    assign LineData     = line_data_q;
    assign LineLast     = line_last_q;
    assign OutlierCount = cnt_q;
    assign Busy         = busy_q;

endmodule

// File: tb/tb_quantized_line_packer.sv
// Directed bench for quantized_line_packer: hand-computed lines, stalls, outliers and reset.
module tb_quantized_line_packer;

    localparam int unsigned L2W = 512;

    logic           Clk;
    logic           Rst_n;
    logic           Start;
    logic [4:0]     bitWidth;
    logic           InValid;
    logic           InReady;
    logic [31:0]    QuantizedBits;
    logic [31:0]    OrigFormat;
    logic           IsOutlier;
    logic           Last;
    logic           LineValid;
    logic           LineReady;
    logic [L2W-1:0] LineData;
    logic           LineLast;
    logic [15:0]    OutlierCount;
    logic           Busy;

    int checks = 0;
    int errors = 0;

    logic [L2W-1:0] lines[$];
    logic           lasts[$];

    quantized_line_packer #(
        .L2_WIDTH       (L2W),
        .WordWidth_WIDTH(32)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Start        (Start),
        .bitWidth     (bitWidth),
        .InValid      (InValid),
        .InReady      (InReady),
        .QuantizedBits(QuantizedBits),
        .OrigFormat   (OrigFormat),
        .IsOutlier    (IsOutlier),
        .Last         (Last),
        .LineValid    (LineValid),
        .LineReady    (LineReady),
        .LineData     (LineData),
        .LineLast     (LineLast),
        .OutlierCount (OutlierCount),
        .Busy         (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Record every line handshake; inputs change just after posedge, so negedge is stable.
    always @(negedge Clk) begin
        if (Rst_n && LineValid && LineReady) begin
            lines.push_back(LineData);
            lasts.push_back(LineLast);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [L2W-1:0] obs, input logic [L2W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_block(input logic [4:0] bw);
        Start    = 1'b1;
        bitWidth = bw;
        tick();
        Start    = 1'b0;
        bitWidth = 5'd3;
    endtask

    task automatic send_word(input logic [31:0] q, input logic [31:0] o, input logic outl, input logic lst);
        int n;
        n             = 0;
        InValid       = 1'b1;
        QuantizedBits = q;
        OrigFormat    = o;
        IsOutlier     = outl;
        Last          = lst;
        forever begin
            @(negedge Clk);
            if (InReady) break;
            n++;
            if (n >= 100) begin
                checks++;
                errors++;
                $error("FAIL accept_timeout: observed InReady low for %0d cycles required accept", n);
                break;
            end
        end
        tick();
        InValid   = 1'b0;
        IsOutlier = 1'b0;
        Last      = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (Busy && n < 400) begin
            tick();
            n++;
        end
        check(tag, L2W'(Busy), L2W'(0));
    endtask

    task automatic clear_lines();
        lines.delete();
        lasts.delete();
    endtask

    initial begin
        logic [L2W-1:0] exp;
        logic [L2W-1:0] saved;
        int             ready_seen;
        int             unstable;

        Rst_n         = 1'b0;
        Start         = 1'b0;
        bitWidth      = 5'd0;
        InValid       = 1'b0;
        QuantizedBits = '0;
        OrigFormat    = '0;
        IsOutlier     = 1'b0;
        Last          = 1'b0;
        LineReady     = 1'b1;
        #1;
        check("rst_inready",   L2W'(InReady),      L2W'(0));
        check("rst_linevalid", L2W'(LineValid),    L2W'(0));
        check("rst_linedata",  LineData,           L2W'(0));
        check("rst_linelast",  L2W'(LineLast),     L2W'(0));
        check("rst_outliers",  L2W'(OutlierCount), L2W'(0));
        check("rst_busy",      L2W'(Busy),         L2W'(0));
        tick();
        tick();
        Rst_n = 1'b1;
        tick();

        // bw=0 means 32: sixteen words fill exactly one final line.
        clear_lines();
        start_block(5'd0);
        check("t1_busy_up", L2W'(Busy), L2W'(1));
        for (int k = 0; k < 16; k++) send_word(32'(k), 32'h0, 1'b0, k == 15);
        check("t1_linevalid_next", L2W'(LineValid), L2W'(1));
        check("t1_linelast_next",  L2W'(LineLast),  L2W'(1));
        wait_idle("t1_idle");
        exp = '0;
        for (int k = 0; k < 16; k++) exp[32*k +: 32] = 32'(k);
        check("t1_nlines", L2W'(lines.size()), L2W'(1));
        if (lines.size() >= 1) begin
            check("t1_line0", lines[0], exp);
            check("t1_last0", L2W'(lasts[0]), L2W'(1));
        end
        check("t1_outliers", L2W'(OutlierCount), L2W'(0));

        // bw=5, 103 words: 515 bits -> full line plus 3-bit residue; mid-block Start ignored.
        clear_lines();
        start_block(5'd5);
        for (int k = 0; k < 103; k++) begin
            if (k == 50) begin
                Start    = 1'b1;
                bitWidth = 5'd7;
                tick();
                Start = 1'b0;
                tick();
            end
            send_word(32'hABCDE01F, 32'h0, 1'b0, k == 102);
        end
        wait_idle("t2_idle");
        check("t2_nlines", L2W'(lines.size()), L2W'(2));
        if (lines.size() >= 2) begin
            check("t2_line0", lines[0], {L2W{1'b1}});
            check("t2_last0", L2W'(lasts[0]), L2W'(0));
            check("t2_line1", lines[1], L2W'(7));
            check("t2_last1", L2W'(lasts[1]), L2W'(1));
        end

        // bw=8, 128 words with a 10-cycle consumer stall after the first line.
        clear_lines();
        LineReady = 1'b1;
        start_block(5'd8);
        for (int k = 0; k < 63; k++) send_word(32'(k), 32'h0, 1'b0, 1'b0);
        LineReady = 1'b0;
        send_word(32'd63, 32'h0, 1'b0, 1'b0);
        check("t3_linevalid", L2W'(LineValid), L2W'(1));
        saved         = LineData;
        InValid       = 1'b1;
        QuantizedBits = 32'd64;
        ready_seen    = 0;
        unstable      = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            if (InReady) ready_seen++;
            if (!LineValid || (LineData !== saved)) unstable++;
            tick();
        end
        check("t3_stall_inready", L2W'(ready_seen), L2W'(0));
        check("t3_stall_stable",  L2W'(unstable),   L2W'(0));
        LineReady = 1'b1;
        for (int k = 64; k < 128; k++) send_word(32'(k), 32'h0, 1'b0, k == 127);
        wait_idle("t3_idle");
        check("t3_nlines", L2W'(lines.size()), L2W'(2));
        if (lines.size() >= 2) begin
            exp = '0;
            for (int j = 0; j < 64; j++) exp[8*j +: 8] = 8'(j);
            check("t3_line0", lines[0], exp);
            check("t3_last0", L2W'(lasts[0]), L2W'(0));
            exp = '0;
            for (int j = 0; j < 64; j++) exp[8*j +: 8] = 8'(64 + j);
            check("t3_line1", lines[1], exp);
            check("t3_last1", L2W'(lasts[1]), L2W'(1));
        end

        // bw=4, eight words, word 3 is an outlier carrying 0xDEADBEEF.
        clear_lines();
        start_block(5'd4);
        for (int k = 0; k < 8; k++) send_word(32'hA0 + 32'(k), 32'hDEADBEEF, k == 3, k == 7);
        wait_idle("t4_idle");
`ifdef QLP_OUTLIER_ESCAPE_EN
        exp = L2W'(64'h7654DEADBEEFF210);
`else
        exp = L2W'(32'h76543210);
`endif
        check("t4_nlines", L2W'(lines.size()), L2W'(1));
        if (lines.size() >= 1) begin
            check("t4_line0", lines[0], exp);
            check("t4_last0", L2W'(lasts[0]), L2W'(1));
        end
        check("t4_outliers", L2W'(OutlierCount), L2W'(1));

        // Reset pulse while a line is pending, then a clean short block.
        clear_lines();
        LineReady = 1'b0;
        start_block(5'd0);
        for (int k = 0; k < 16; k++) send_word(32'h100 + 32'(k), 32'h12345678, k == 15, 1'b0);
        check("t5_pending_valid", L2W'(LineValid),    L2W'(1));
        check("t5_pending_outl",  L2W'(OutlierCount), L2W'(1));
        Rst_n = 1'b0;
        #1;
        check("t5_rst_inready",   L2W'(InReady),      L2W'(0));
        check("t5_rst_linevalid", L2W'(LineValid),    L2W'(0));
        check("t5_rst_linedata",  LineData,           L2W'(0));
        check("t5_rst_linelast",  L2W'(LineLast),     L2W'(0));
        check("t5_rst_outliers",  L2W'(OutlierCount), L2W'(0));
        check("t5_rst_busy",      L2W'(Busy),         L2W'(0));
        tick();
        Rst_n = 1'b1;
        tick();
        clear_lines();
        LineReady = 1'b1;
        start_block(5'd16);
        send_word(32'h1234ABCD, 32'h0, 1'b0, 1'b0);
        send_word(32'h00005678, 32'h0, 1'b0, 1'b1);
        wait_idle("t5_idle");
        check("t5_nlines", L2W'(lines.size()), L2W'(1));
        if (lines.size() >= 1) begin
            check("t5_line0", lines[0], L2W'(32'h5678ABCD));
            check("t5_last0", L2W'(lasts[0]), L2W'(1));
        end
        check("t5_outliers", L2W'(OutlierCount), L2W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
